// File: rtl/uart_rx_if.sv
// Bus between the UART receiver and its consumer: serial line in, FIFO pop,
// sticky error clear, and the FIFO head / status flags coming back.
interface uart_rx_if;
  logic       sIn;
  logic       rdEn;
  logic       errClr;
  logic [7:0] data;
  logic       fifoEmpty;
  logic       fifoFull;
  logic       overrun;
  logic       frameErr;

  // Consumer side: drives the line and the controls, reads data and flags.
  modport master (
    output sIn, rdEn, errClr,
    input  data, fifoEmpty, fifoFull, overrun, frameErr
  );

  // Receiver side.
  modport slave (
    input  sIn, rdEn, errClr,
    output data, fifoEmpty, fifoFull, overrun, frameErr
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, break handling, a first-word
// fall-through receive FIFO and sticky overrun / framing error flags.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input logic     clk,
  input logic     rst,
  uart_rx_if.slave bus
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [15:0] HALF_T = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_T  = 16'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} stateT;

  logic        sMeta;
  logic        sSync;
  stateT       state;
  logic [15:0] timer;
  logic [2:0]  bitIdx;
  logic [7:0]  shiftReg;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wrPtr;
  logic [AW:0] rdPtr;
  logic        overrunReg;
  logic        frameErrReg;

  logic        bitDone;
  logic        halfDone;
  logic        pushReq;
  logic        stopBad;
  logic        isEmpty;
  logic        isFull;
  logic        popOk;
  logic        pushOk;
  logic        dropEvt;

  assign bitDone  = (timer == BIT_T);
  assign halfDone = (timer == HALF_T);

  // The stop-bit sample edge is also the FIFO write edge, so the byte is
  // visible on data the very next cycle.
  assign pushReq  = (state == STOP) && bitDone && sSync;
  assign stopBad  = (state == STOP) && bitDone && !sSync;

  assign isEmpty  = (wrPtr == rdPtr);
  assign isFull   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign popOk    = bus.rdEn && !isEmpty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is fine then.
  assign pushOk   = pushReq && (!isFull || popOk);
  assign dropEvt  = pushReq && isFull && !popOk;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sMeta <= 1'b1;
      sSync <= 1'b1;
    end else begin
      sMeta <= bus.sIn;
      sSync <= sMeta;
    end
  end

  // Frame FSM: start detect, half-bit start check, eight data samples, stop check.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= 16'd0;
      bitIdx   <= 3'd0;
      shiftReg <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          timer <= 16'd0;
          if (!sSync) state <= START;
        end
        START: begin
          if (halfDone) begin
            timer  <= 16'd0;
            bitIdx <= 3'd0;
            state  <= sSync ? IDLE : DATA;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        DATA: begin
          if (bitDone) begin
            shiftReg[bitIdx] <= sSync;
            timer            <= 16'd0;
            if (bitIdx == 3'd7) state <= STOP;
            else                bitIdx <= bitIdx + 3'd1;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        STOP: begin
          if (bitDone) begin
            timer <= 16'd0;
            state <= sSync ? IDLE : BREAK;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        BREAK: begin
          timer <= 16'd0;
          if (sSync) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && pushOk) mem[wrPtr[AW-1:0]] <= shiftReg;
  end

  // FIFO pointers, one extra bit to tell full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + PTR_ONE;
      if (popOk)  rdPtr <= rdPtr + PTR_ONE;
    end
  end

  // Sticky error flags; a new event outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrunReg  <= 1'b0;
      frameErrReg <= 1'b0;
    end else begin
      overrunReg  <= dropEvt | (overrunReg & ~bus.errClr);
      frameErrReg <= stopBad | (frameErrReg & ~bus.errClr);
    end
  end

  // Fall-through head; forced to zero while empty so reset reads 0x00.
  assign bus.data      = isEmpty ? 8'h00 : mem[rdPtr[AW-1:0]];
  assign bus.fifoEmpty = isEmpty;
  assign bus.fifoFull  = isFull;
  assign bus.overrun   = overrunReg;
  assign bus.frameErr  = frameErrReg;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per serial bit (50 MHz / 115200); legal range 4..65535.
REQ-002 Parameter FIFO_DEPTH, default 16, receive FIFO entries; power of two, at least 2.
REQ-003 clk  input  1  single clock for all logic (clk_cpu domain).
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sIn  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-006 rdEn  input  1  pop FIFO head at this clk edge.
REQ-007 errClr  input  1  clear sticky error flags at this clk edge.
REQ-008 data  output  8  FIFO head byte, first-word fall-through; valid only when fifoEmpty=0.
REQ-009 fifoEmpty  output  1  FIFO holds no bytes.
REQ-010 fifoFull  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-011 overrun  output  1  sticky: a good frame was dropped because the FIFO was full.
REQ-012 frameErr  output  1  sticky: a frame was discarded because its stop bit sampled low.

Function
REQ-013 sIn SHALL pass through a 2-flop synchronizer (both flops reset to 1) before any use; sSync denotes its output.
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP, BREAK, plus a bit-timer (16 bits) and a bit index (3 bits).
REQ-015 IDLE: sSync=0 -> START with timer cleared; otherwise remain.
REQ-016 START: at timer = CLKS_PER_BIT/2 - 1, sample sSync; 0 -> DATA with timer cleared, index 0; 1 -> IDLE (glitch rejected, nothing recorded).
REQ-017 DATA: at timer = CLKS_PER_BIT-1, sample sSync into shift bit [index], clear timer; after index 7 -> STOP.
REQ-018 STOP: at timer = CLKS_PER_BIT-1, sample sSync; 1 -> push byte, IDLE; 0 -> set frameErr, discard byte, BREAK.
REQ-019 BREAK: remain until sSync=1, then IDLE (no new start detected during a held-low line).
REQ-020 Push into a full FIFO SHALL drop the byte, set overrun, and leave FIFO contents unchanged, unless rdEn is asserted in the same cycle.
REQ-021 Simultaneous push and pop: pop head and append new byte; occupancy unchanged; legal when full or non-empty.
REQ-022 rdEn while fifoEmpty=1 SHALL be ignored; pointers and flags unchanged.
REQ-023 Simultaneous push and pop while empty: the byte is stored; occupancy becomes 1.
REQ-024 A pushed byte SHALL appear on data with fifoEmpty=0 the cycle after the STOP sample edge.
REQ-025 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full = MSBs differ with lower bits equal.
REQ-026 errClr SHALL clear overrun and frameErr; an error event in the same cycle SHALL win (the flag remains set).
REQ-027 Sampling points SHALL be mid-bit: the start bit sample at CLKS_PER_BIT/2 cycles after detection, each later sample CLKS_PER_BIT cycles apart.

Reset
REQ-028 rst SHALL force state IDLE, timer 0, index 0, synchronizer flops 1, FIFO pointers 0, fifoEmpty=1, fifoFull=0, overrun=0, frameErr=0, data=0x00.
REQ-029 rst asserted mid-frame SHALL abandon the partial byte; after release a low sSync is treated as a new start bit.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-030 Frame 0xA5 on sIn -> data=0xA5, fifoEmpty=0 one cycle after STOP sample; rdEn pulse -> fifoEmpty=1.
REQ-031 Low glitch of 1 cycle on idle sIn -> no push; state returns to IDLE; flags 0.
REQ-032 Five frames 0x01..0x05 with no reads -> fifoFull=1 after the 4th frame, overrun=1 after the 5th; pops return 0x01..0x04.
REQ-033 Frame 0x3C with stop bit low, line held low 20 cycles, then frame 0x5A -> frameErr=1, FIFO holds only 0x5A; errClr -> frameErr=0.
REQ-034 FIFO full with rdEn asserted at the push cycle -> overrun stays 0, occupancy stays 4, oldest byte removed.
REQ-035 rst pulsed during DATA bit 3 -> all outputs at reset values; next full frame 0x7E is received correctly.
